// File: rtl/pipeline_register_pkg.sv
// Shared defaults and helpers for the elastic pipeline register.
package pipeline_register_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_RESET_VALUE = 0;

  // Width of an occupancy counter able to hold 0..depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipeline_register_stage.sv
// One elastic stage: a data register plus valid bit with a ready/valid
// handshake on both sides. An empty stage always accepts, which collapses
// bubbles even while downstream is stalled.
module pipe_stage
  import pipeline_register_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             up_ready_o,
  input  logic             down_ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             adv, load;

  assign adv        = valid_q & down_ready_i;
  assign up_ready_o = ~valid_q | adv;
  // Flush blocks loads so the data register is left untouched.
  assign load       = up_valid_i & up_ready_o & ~flush_i;

  // Next-state: flush clears, load fills, a departing word empties.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i)  valid_d = 1'b0;
    else if (load) valid_d = 1'b1;
    else if (adv)  valid_d = 1'b0;
    if (load) data_d = up_data_i;
  end

  // Stage state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VALUE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipeline_register.sv
// Elastic DEPTH-stage pipeline register with ready/valid on both ends.
// Optional occupancy output enabled by macro PIPELINE_REGISTER_COUNT_EN.
module pipeline_register
  import pipeline_register_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter int               DEPTH       = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEF_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPELINE_REGISTER_COUNT_EN
  ,
  output logic [count_width(DEPTH)-1:0] count
`endif
);

  logic [DEPTH-1:0]            stg_valid;
  logic [DEPTH-1:0][WIDTH-1:0] stg_data;

  // Ready ripples back from the output through per-stage nets so each
  // stage only sees its direct successor.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             dn_ready;
    logic             rdy;

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = data_in;
    end else begin : g_link
      assign up_valid = stg_valid[i-1];
      assign up_data  = stg_data[i-1];
    end

    // No output transfer completes while flushing.
    if (i == DEPTH - 1) begin : g_tail
      assign dn_ready = out_ready & ~flush;
    end else begin : g_next
      assign dn_ready = g_stage[i+1].rdy;
    end

    pipe_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk          (clk),
      .reset        (reset),
      .flush_i      (flush),
      .up_valid_i   (up_valid),
      .up_data_i    (up_data),
      .up_ready_o   (rdy),
      .down_ready_i (dn_ready),
      .valid_o      (stg_valid[i]),
      .data_o       (stg_data[i])
    );
  end

  // Reset is folded in so the port reads 0 for the whole reset window.
  assign in_ready  = g_stage[0].rdy & ~flush & ~reset;
  assign out_valid = stg_valid[DEPTH-1] & ~flush;
  assign data_out  = stg_data[DEPTH-1];

`ifdef PIPELINE_REGISTER_COUNT_EN
  localparam int CW = count_width(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic          in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Occupancy tracks transfers; simultaneous in and out cancel.
  always_comb begin
    count_d = count_q;
    if (flush)                    count_d = '0;
    else if (in_xfer && !out_xfer) count_d = count_q + CW'(1);
    else if (out_xfer && !in_xfer) count_d = count_q - CW'(1);
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
`endif

endmodule
